// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and small helpers for the writeback arbiter.
// Imported by the arbiter interface, picker and top.
package regfile_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;

    // Increment with wrap for non power-of-two requester counts.
    function automatic int wrapInc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus and register-file write port bundle.
// Master side is the requesters/regfile, slave side is the arbiter.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        i_reqValid;
    logic [NUM_REQ*ADDR_W-1:0] i_reqAdd;
    logic [NUM_REQ*DATA_W-1:0] i_reqData;
    logic [NUM_REQ-1:0]        o_reqReady;
    logic                      o_writeEn;
    logic [ADDR_W-1:0]         o_writeAdd;
    logic [DATA_W-1:0]         o_writeData;
    logic [ID_W-1:0]           o_grantId;

    modport master (
        output i_reqValid,
        output i_reqAdd,
        output i_reqData,
        input  o_reqReady,
        input  o_writeEn,
        input  o_writeAdd,
        input  o_writeData,
        input  o_grantId
    );

    modport slave (
        input  i_reqValid,
        input  i_reqAdd,
        input  i_reqData,
        output o_reqReady,
        output o_writeEn,
        output o_writeAdd,
        output o_writeData,
        output o_grantId
    );

endinterface

// File: rtl/regfile_write_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after rrPtr.
// Produces a one-hot grant, the winner index and an any-grant flag.
module rr_priority_picker
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rrPtr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winIdx,
    output logic               anyGrant
);

    int cand;

    always_comb begin
        grant    = '0;
        winIdx   = '0;
        anyGrant = 1'b0;
        cand     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rrPtr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!anyGrant && req[cand]) begin
                anyGrant    = 1'b1;
                grant[cand] = 1'b1;
                winIdx      = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, registered output.
// Optional REGFILE_WR_R0_DROP_EN: address-0 writes are granted but never enabled.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_rstN,
    input  logic                  i_stall,
    regfile_write_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    rrPtr;
    logic [ID_W-1:0]    nextPtr;
    logic [ID_W-1:0]    winIdx;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               anyGrant;
    logic               wrKeep;

    logic [ADDR_W-1:0]  addArr [NUM_REQ];
    logic [DATA_W-1:0]  dataArr [NUM_REQ];
    logic [ADDR_W-1:0]  winAdd;
    logic [DATA_W-1:0]  winData;

    logic               writeEnQ;
    logic [ADDR_W-1:0]  writeAddQ;
    logic [DATA_W-1:0]  writeDataQ;
    logic [ID_W-1:0]    grantIdQ;

    // Reset and stall both mask every request before the picker sees it.
    assign eligible = (i_rstN && !i_stall) ? bus.i_reqValid : '0;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) picker (
        .req      (eligible),
        .rrPtr    (rrPtr),
        .grant    (grant),
        .winIdx   (winIdx),
        .anyGrant (anyGrant)
    );

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign addArr[k]  = bus.i_reqAdd[k*ADDR_W +: ADDR_W];
        assign dataArr[k] = bus.i_reqData[k*DATA_W +: DATA_W];
    end

    assign winAdd  = addArr[winIdx];
    assign winData = dataArr[winIdx];
    assign nextPtr = ID_W'(wrapInc(int'(winIdx), NUM_REQ));

`ifdef REGFILE_WR_R0_DROP_EN
    assign wrKeep = (winAdd != ADDR_W'(RF_ZERO_REG));
`else
    assign wrKeep = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            rrPtr      <= '0;
            writeEnQ   <= 1'b0;
            writeAddQ  <= '0;
            writeDataQ <= '0;
            grantIdQ   <= '0;
        end else begin
            writeEnQ <= anyGrant & wrKeep;
            if (anyGrant) begin
                rrPtr      <= nextPtr;
                writeAddQ  <= winAdd;
                writeDataQ <= winData;
                grantIdQ   <= winIdx;
            end
        end
    end

    assign bus.o_reqReady  = grant;
    assign bus.o_writeEn   = writeEnQ;
    assign bus.o_writeAdd  = writeAddQ;
    assign bus.o_writeData = writeDataQ;
    assign bus.o_grantId   = grantIdQ;

endmodule
